multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I-subset datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and issues one-cycle write enables for the PC, IR, register file and data memory.
- Handles variable-latency memories with ready handshakes, a stall timeout, and a retired-instruction counter.
- Sits beside the opcode decoder: OP comes from the IR; this block owns *when* things are written.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- WAIT_MAX, 15, max consecutive not-ready cycles tolerated in FETCH or MEM before the error halt (1..255).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- OP  input  7  opcode from IR; valid from the cycle after IR_WE.
- IMEM_RDY  input  1  instruction memory data valid this cycle.
- DMEM_RDY  input  1  data memory access completes this cycle.
- IR_WE  output  1  load IR.
- PC_WE  output  1  update PC (retire strobe).
- RF_WE  output  1  register-file write.
- DM_RE  output  1  data memory read request.
- DM_WE  output  1  data memory write request.
- STATE  output  3  current state encoding.
- MEM_ERR  output  1  sticky timeout flag.
- RETIRED  output  CNT_W  retired-instruction count.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6 (TRAP exists only with the optional feature).
- Reset (async, RST_N=0): STATE=FETCH, opcode-class register=0, wait counter=0, MEM_ERR=0, RETIRED=0.
  - All enables are 0 while in reset.
  - Reset mid-instruction aborts it; no enable fires for the aborted instruction.
- Enables are combinational from the registered state, the latched class and the ready inputs:
  - IR_WE = FETCH & IMEM_RDY.
  - DM_RE = MEM & load; DM_WE = MEM & store; both held high until DMEM_RDY.
  - RF_WE = WB.
  - PC_WE asserted exactly once per instruction, in its final cycle.
- FETCH: stays while IMEM_RDY=0; on IMEM_RDY=1 goes to DECODE.
- DECODE: OP latched into a class register:
  - LOAD 0000011, STORE 0100011, ALU 0110011/0010011, BRANCH 1100011, JAL 1101111, LUI 0110111, AUIPC 0010111, else ILLEGAL.
  - ILLEGAL: PC_WE=1 (retired as NOP), next state FETCH.
  - Every other class goes to EXEC.
- EXEC:
  - BRANCH: PC_WE=1, next state FETCH.
  - LOAD/STORE: next state MEM.
  - ALU/JAL/LUI/AUIPC: next state WB.
- MEM: waits for DMEM_RDY.
  - On ready, STORE: PC_WE=1, next state FETCH.
  - On ready, LOAD: next state WB.
- WB: RF_WE=1, PC_WE=1, next state FETCH.
- Latency with zero-wait memories:
  - BRANCH: 3 cycles; STORE, ALU/JAL/LUI/AUIPC: 4 cycles; LOAD: 5 cycles; ILLEGAL: 2 cycles.
- Wait counter:
  - Increments each cycle in FETCH with IMEM_RDY=0, or in MEM with DMEM_RDY=0.
  - Clears on any state change or when ready is seen.
  - When it would reach WAIT_MAX, next state is HALT and MEM_ERR is set.
  - Ready arriving in that same cycle wins: normal transition, no error.
- HALT: absorbing until reset. All enables 0; MEM_ERR stays 1.
- RETIRED: increments on every PC_WE cycle and wraps modulo 2^CNT_W.
- Out-of-range STATE values (7, or 6 without the feature) recover to FETCH on the next edge.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - ILLEGAL in DECODE goes to TRAP with no PC_WE and no RETIRED increment.
  - TRAP is absorbing until reset; all enables 0; STATE=6; MEM_ERR unaffected.
- Undefined: ILLEGAL is retired as a NOP as above; TRAP is not implemented.

Test Plan:
- Reset, then ADD (0110011) with IMEM_RDY=1 → STATE 0,1,2,4,0; IR_WE in cycle 1; RF_WE and PC_WE in cycle 4; RETIRED=1.
- LW (0000011) with DMEM_RDY low for 3 MEM cycles → DM_RE high 4 cycles; WB one cycle later; total 8 cycles; RF_WE=1 once.
- SW then BEQ back-to-back → SW: DM_WE in MEM, PC_WE at MEM exit, no RF_WE. BEQ: PC_WE in EXEC, 3 cycles. RETIRED=2.
- IMEM_RDY held 0 with WAIT_MAX=15 → HALT entered after 15 wait cycles; MEM_ERR=1. A later IMEM_RDY=1 has no effect. RST_N pulse clears MEM_ERR and STATE returns to 0.
- OP=1111111: without the macro, PC_WE in DECODE and RETIRED+1; with ILLEGAL_TRAP_EN, STATE=6, RETIRED unchanged, no enables.
- CNT_W=4, 16 ADDs → RETIRED wraps to 0. RST_N asserted in MEM with DM_WE high → DM_WE drops immediately (async) and STATE=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer issuing one-cycle write enables.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcodes trap instead of retiring as NOP).
module multicycle_ctrl #(
   parameter int CNT_W    = 32,
   parameter int WAIT_MAX = 15
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [6:0]       OP,
   input  logic             IMEM_RDY,
   input  logic             DMEM_RDY,
   output logic             IR_WE,
   output logic             PC_WE,
   output logic             RF_WE,
   output logic             DM_RE,
   output logic             DM_WE,
   output logic [2:0]       STATE,
   output logic             MEM_ERR,
   output logic [CNT_W-1:0] RETIRED
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;
`ifdef ILLEGAL_TRAP_EN
   localparam logic [2:0] S_TRAP   = 3'd6;
`endif

   localparam logic [2:0] C_ILL    = 3'd0;
   localparam logic [2:0] C_LOAD   = 3'd1;
   localparam logic [2:0] C_STORE  = 3'd2;
   localparam logic [2:0] C_ALU    = 3'd3;
   localparam logic [2:0] C_BRANCH = 3'd4;
   localparam logic [2:0] C_JAL    = 3'd5;
   localparam logic [2:0] C_LUI    = 3'd6;
   localparam logic [2:0] C_AUIPC  = 3'd7;

   localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

   logic [2:0]       state_q, state_d;
   logic [2:0]       cls_q, cls_d;
   logic [7:0]       wait_q, wait_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] ret_q, ret_d;
   logic [2:0]       op_cls;
   logic [7:0]       wait_inc;
   logic             ir_we, pc_we, rf_we, dm_re, dm_we;

   always_comb begin
      case (OP)
         7'b0000011:             op_cls = C_LOAD;
         7'b0100011:             op_cls = C_STORE;
         7'b0110011, 7'b0010011: op_cls = C_ALU;
         7'b1100011:             op_cls = C_BRANCH;
         7'b1101111:             op_cls = C_JAL;
         7'b0110111:             op_cls = C_LUI;
         7'b0010111:             op_cls = C_AUIPC;
         default:                op_cls = C_ILL;
      endcase
   end

   assign wait_inc = wait_q + 8'd1;

   // Wait counter defaults to clear; only a not-ready cycle in FETCH/MEM keeps counting.
   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      wait_d  = 8'd0;
      err_d   = err_q;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      rf_we   = 1'b0;
      dm_re   = 1'b0;
      dm_we   = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (IMEM_RDY) begin
               ir_we   = 1'b1;
               state_d = S_DECODE;
            end else if (wait_inc == WAIT_LIM) begin
               state_d = S_HALT;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_inc;
            end
         end
         S_DECODE: begin
            cls_d = op_cls;
            if (op_cls == C_ILL) begin
`ifdef ILLEGAL_TRAP_EN
               state_d = S_TRAP;
`else
               pc_we   = 1'b1;
               state_d = S_FETCH;
`endif
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (cls_q)
               C_BRANCH: begin
                  pc_we   = 1'b1;
                  state_d = S_FETCH;
               end
               C_LOAD, C_STORE: state_d = S_MEM;
               default:         state_d = S_WB;
            endcase
         end
         S_MEM: begin
            dm_re = (cls_q == C_LOAD);
            dm_we = (cls_q == C_STORE);
            if (DMEM_RDY) begin
               if (cls_q == C_LOAD) begin
                  state_d = S_WB;
               end else begin
                  pc_we   = (cls_q == C_STORE);
                  state_d = S_FETCH;
               end
            end else if (wait_inc == WAIT_LIM) begin
               state_d = S_HALT;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_inc;
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT: state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
         S_TRAP: state_d = S_TRAP;
`endif
         default: state_d = S_FETCH;
      endcase
      ret_d = ret_q + {{(CNT_W-1){1'b0}}, pc_we};
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_FETCH;
         cls_q   <= C_ILL;
         wait_q  <= 8'd0;
         err_q   <= 1'b0;
         ret_q   <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         ret_q   <= ret_d;
      end
   end

   // Gating with RST_N keeps IR_WE quiet while reset holds the FSM in FETCH.
   assign IR_WE   = ir_we & RST_N;
   assign PC_WE   = pc_we & RST_N;
   assign RF_WE   = rf_we & RST_N;
   assign DM_RE   = dm_re & RST_N;
   assign DM_WE   = dm_we & RST_N;
   assign STATE   = state_q;
   assign MEM_ERR = err_q;
   assign RETIRED = ret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: random instruction stream plus directed stall/reset cases.
module tb_multicycle_ctrl;

   localparam int CNT_W = 4;
   localparam int WAIT_MAX = 15;

   logic             CLK = 1'b0;
   logic             RST_N;
   logic [6:0]       OP;
   logic             IMEM_RDY, DMEM_RDY;
   logic             IR_WE, PC_WE, RF_WE, DM_RE, DM_WE, MEM_ERR;
   logic [2:0]       STATE;
   logic [CNT_W-1:0] RETIRED;

   multicycle_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
      .CLK(CLK), .RST_N(RST_N), .OP(OP), .IMEM_RDY(IMEM_RDY), .DMEM_RDY(DMEM_RDY),
      .IR_WE(IR_WE), .PC_WE(PC_WE), .RF_WE(RF_WE), .DM_RE(DM_RE), .DM_WE(DM_WE),
      .STATE(STATE), .MEM_ERR(MEM_ERR), .RETIRED(RETIRED)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int len; int rf; int dre; int dwe; int ret;
   } exp_t;

   exp_t exp_q[$];
   int   st_q[$];
   int   n_cmp = 0, n_err = 0;
   bit   mon_en = 0;
   bit   pend_ret = 0;
   int   pend_val;
   int   cyc, ir_n, rf_n, dre_n, dwe_n;
   int   ret_model = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // 0 illegal, 1 load, 2 store, 3 register-writing (ALU/JAL/LUI/AUIPC), 4 branch
   function automatic int kind_of(input logic [6:0] op);
      case (op)
         7'b0000011: return 1;
         7'b0100011: return 2;
         7'b0110011, 7'b0010011, 7'b1101111, 7'b0110111, 7'b0010111: return 3;
         7'b1100011: return 4;
         default: return 0;
      endcase
   endfunction

   // Called just after a rising edge with the DUT in FETCH; drives one full instruction.
   task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
      int   k, len, st;
      exp_t e;
      k = kind_of(op);
      case (k)
         0: len = fw + 2;
         1: len = fw + mw + 5;
         2: len = fw + mw + 4;
         3: len = fw + 4;
         default: len = fw + 3;
      endcase
      ret_model = (ret_model + 1) % (1 << CNT_W);
      e.len = len;
      e.rf  = (k == 1 || k == 3) ? 1 : 0;
      e.dre = (k == 1) ? mw + 1 : 0;
      e.dwe = (k == 2) ? mw + 1 : 0;
      e.ret = ret_model;
      exp_q.push_back(e);
      for (int c = 0; c < len; c++) begin
         if (c <= fw) st = 0;
         else if (c == fw + 1) st = 1;
         else if (c == fw + 2) st = 2;
         else if ((k == 1 || k == 2) && c <= fw + 3 + mw) st = 3;
         else st = 4;
         st_q.push_back(st);
      end
      for (int c = 0; c < len; c++) begin
         OP = op;
         IMEM_RDY = (c >= fw);
         DMEM_RDY = (c >= fw + 3 + mw);
         @(posedge CLK); #1;
      end
   endtask

   task automatic start_mon();
      exp_q.delete(); st_q.delete();
      cyc = 0; ir_n = 0; rf_n = 0; dre_n = 0; dwe_n = 0;
      pend_ret = 0;
      mon_en = 1;
   endtask

   task automatic stop_mon();
      IMEM_RDY = 0; DMEM_RDY = 0;
      @(negedge CLK); #1;
      mon_en = 0;
      chk("exp_q_drained", exp_q.size(), 0);
      chk("state_q_drained", st_q.size(), 0);
   endtask

   task automatic do_reset();
      RST_N = 0; IMEM_RDY = 0; DMEM_RDY = 0; OP = 7'd0;
      repeat (2) @(posedge CLK);
      #1; RST_N = 1;
      ret_model = 0;
   endtask

   initial begin : monitor
      int   s;
      exp_t e;
      forever begin
         @(negedge CLK);
         if (mon_en) begin
            if (pend_ret) begin
               chk("retired", RETIRED, pend_val);
               pend_ret = 0;
            end
            if (st_q.size() > 0) begin
               s = st_q.pop_front();
               chk("state", STATE, s);
               cyc++;
               ir_n += IR_WE; rf_n += RF_WE; dre_n += DM_RE; dwe_n += DM_WE;
               if (PC_WE) begin
                  if (exp_q.size() == 0) begin
                     chk("unexpected_retire", 1, 0);
                  end else begin
                     e = exp_q.pop_front();
                     chk("instr_len", cyc, e.len);
                     chk("ir_we_count", ir_n, 1);
                     chk("rf_we_count", rf_n, e.rf);
                     chk("dm_re_count", dre_n, e.dre);
                     chk("dm_we_count", dwe_n, e.dwe);
                     pend_val = e.ret;
                     pend_ret = 1;
                  end
                  cyc = 0; ir_n = 0; rf_n = 0; dre_n = 0; dwe_n = 0;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [6:0] ops [10];
      int nops;
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
              7'b1101111, 7'b0110111, 7'b0010111, 7'b1111111, 7'b0000000};
`ifdef ILLEGAL_TRAP_EN
      nops = 8;
`else
      nops = 10;
`endif

      // Reset state with IMEM_RDY high: no enables may fire.
      RST_N = 0; IMEM_RDY = 1; DMEM_RDY = 1; OP = 7'b0110011;
      @(posedge CLK); #1;
      chk("rst_state", STATE, 0);
      chk("rst_ir_we", IR_WE, 0);
      chk("rst_pc_we", PC_WE, 0);
      chk("rst_mem_err", MEM_ERR, 0);
      chk("rst_retired", RETIRED, 0);
      do_reset();

      // Directed: SW then BEQ, then random stream.
      start_mon();
      run_instr(7'b0100011, 0, 0);
      run_instr(7'b1100011, 0, 0);
      run_instr(7'b0000011, 0, 3);
      for (int i = 0; i < 60; i++)
         run_instr(ops[$urandom_range(0, nops - 1)], $urandom_range(0, 4), $urandom_range(0, 4));
      stop_mon();

      // Ready arriving on the would-be timeout cycle wins.
      do_reset();
      repeat (WAIT_MAX - 1) begin @(posedge CLK); #1; end
      chk("ready_wins_pre_state", STATE, 0);
      IMEM_RDY = 1;
      #1 chk("ready_wins_ir_we", IR_WE, 1);
      @(posedge CLK); #1;
      chk("ready_wins_state", STATE, 1);
      chk("ready_wins_err", MEM_ERR, 0);

      // FETCH timeout into HALT, then HALT absorbs IMEM_RDY, reset clears.
      do_reset();
      repeat (WAIT_MAX - 1) begin @(posedge CLK); #1; end
      chk("fetch_wait_state", STATE, 0);
      @(posedge CLK); #1;
      chk("fetch_halt_state", STATE, 5);
      chk("fetch_halt_err", MEM_ERR, 1);
      IMEM_RDY = 1;
      repeat (4) begin @(posedge CLK); #1; end
      chk("halt_absorb_state", STATE, 5);
      chk("halt_ir_we", IR_WE, 0);
      chk("halt_err_sticky", MEM_ERR, 1);
      RST_N = 0; #1;
      chk("halt_rst_err", MEM_ERR, 0);
      chk("halt_rst_state", STATE, 0);

      // MEM timeout on a load.
      do_reset();
      IMEM_RDY = 1; OP = 7'b0000011;
      repeat (3) begin @(posedge CLK); #1; end
      chk("mem_state", STATE, 3);
      chk("mem_dm_re", DM_RE, 1);
      IMEM_RDY = 0;
      repeat (WAIT_MAX - 1) begin @(posedge CLK); #1; end
      chk("mem_wait_state", STATE, 3);
      chk("mem_wait_err", MEM_ERR, 0);
      @(posedge CLK); #1;
      chk("mem_halt_state", STATE, 5);
      chk("mem_halt_err", MEM_ERR, 1);
      chk("mem_halt_dm_re", DM_RE, 0);

      // Asynchronous reset while a store is in MEM.
      do_reset();
      IMEM_RDY = 1; OP = 7'b0100011;
      repeat (3) begin @(posedge CLK); #1; end
      chk("sw_mem_dm_we", DM_WE, 1);
      RST_N = 0; #1;
      chk("async_rst_dm_we", DM_WE, 0);
      chk("async_rst_state", STATE, 0);
      chk("async_rst_ir_we", IR_WE, 0);

      // Counter wrap with 16 ADDs.
      do_reset();
      start_mon();
      repeat (16) run_instr(7'b0110011, 0, 0);
      stop_mon();
      chk("wrap_retired", RETIRED, 0);

      // Illegal opcode handling.
      do_reset();
`ifdef ILLEGAL_TRAP_EN
      IMEM_RDY = 1; DMEM_RDY = 1; OP = 7'b1111111;
      @(posedge CLK); #1;
      chk("ill_decode_state", STATE, 1);
      chk("ill_decode_pc_we", PC_WE, 0);
      @(posedge CLK); #1;
      chk("trap_state", STATE, 6);
      repeat (3) begin @(posedge CLK); #1; end
      chk("trap_state_held", STATE, 6);
      chk("trap_enables", {IR_WE, PC_WE, RF_WE, DM_RE, DM_WE}, 0);
      chk("trap_retired", RETIRED, 0);
      chk("trap_err", MEM_ERR, 0);
`else
      start_mon();
      run_instr(7'b1111111, 1, 0);
      run_instr(7'b0110011, 0, 0);
      stop_mon();
      chk("ill_nop_retired", RETIRED, 2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
